// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
//
// Execute stage of the 8-bit pipelined datapath. Sits directly behind the
// ID/EX register: it resolves operand forwarding, runs single-cycle ALU ops
// and an iterative shift-add multiplier and restoring divider (one step per
// cycle). It registers result/flags for EX/MEM and stalls the front end via
// `busy` while a multi-cycle op is in flight.
//
// Build option:
//   EX_DIVIDER_EN  defined   -> op 12 is a real iterative unsigned divide.
//                  undefined -> op 12 completes in one cycle with result 0,
//                               hi 0, Z=1 and V=1; the DIV state is absent.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   valid_in        ID/EX holds a real instruction (0 = bubble)
//   alu_top_select  top operand source: 0 rf, 1 EX/MEM, 2 MEM/WB, 3 imm, else 0
//   alu_bot_select  bottom operand source, same encoding
//   top_in, bot_in  register-file operands
//   instruction_in  instruction word; op = [29:26], immediate = [7:0]
//   fwd_ex_mem      forwarded EX/MEM result
//   fwd_mem_wb      forwarded MEM/WB result
//   result_out      registered result (product low byte / quotient)
//   result_hi_out   registered product high byte / remainder, else 0
//   flags_out       registered {Z, N, C, V}
//   valid_out       one-cycle pulse when result/flags are new
//   busy            combinational stall request to PC, IF/ID and ID/EX
// -----------------------------------------------------------------------------
module ex_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int ITER       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [4:0]            alu_top_select,
    input  logic [4:0]            alu_bot_select,
    input  logic [DATA_WIDTH-1:0] top_in,
    input  logic [DATA_WIDTH-1:0] bot_in,
    input  logic [31:0]           instruction_in,
    input  logic [DATA_WIDTH-1:0] fwd_ex_mem,
    input  logic [DATA_WIDTH-1:0] fwd_mem_wb,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic [DATA_WIDTH-1:0] result_hi_out,
    output logic [3:0]            flags_out,
    output logic                  valid_out,
    output logic                  busy
);

    localparam int MSB   = DATA_WIDTH - 1;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ASR  = 4'd8;
    localparam logic [3:0] OP_PASA = 4'd9;
    localparam logic [3:0] OP_PASB = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

`ifdef EX_DIVIDER_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

    state_t state, state_nxt;

    // Operand source select shared by both operand muxes.
    function automatic logic [DATA_WIDTH-1:0] pick_operand(
        input logic [4:0]            sel,
        input logic [DATA_WIDTH-1:0] rf_val,
        input logic [DATA_WIDTH-1:0] ex_mem_val,
        input logic [DATA_WIDTH-1:0] mem_wb_val,
        input logic [DATA_WIDTH-1:0] imm_val
    );
        case (sel)
            5'd0:    pick_operand = rf_val;
            5'd1:    pick_operand = ex_mem_val;
            5'd2:    pick_operand = mem_wb_val;
            5'd3:    pick_operand = imm_val;
            default: pick_operand = '0;
        endcase
    endfunction

    // {Z, N, C, V}; Z and N always follow the low result byte.
    function automatic logic [3:0] pack_flags(
        input logic [DATA_WIDTH-1:0] res,
        input logic                  c,
        input logic                  v
    );
        pack_flags = {(res == '0), res[MSB], c, v};
    endfunction

    logic [3:0]                   op_p0;
    logic [DATA_WIDTH-1:0]        imm_p0;
    logic [DATA_WIDTH-1:0]        top_op_p0;
    logic [DATA_WIDTH-1:0]        bot_op_p0;
    logic signed [DATA_WIDTH-1:0] top_s_p0;
    logic                         is_multi_p0;
    logic                         accept_multi_p0;
    logic                         load_single_p0;
    logic [DATA_WIDTH:0]          wide_p0;
    logic [DATA_WIDTH-1:0]        alu_res_p0;
    logic                         alu_c_p0;
    logic                         alu_v_p0;

    logic [CNT_W-1:0]             cnt_p1;
    logic                         load_iter_p1;
    logic [DATA_WIDTH-1:0]        work_hi_p1;
    logic [DATA_WIDTH-1:0]        work_lo_p1;
    logic [DATA_WIDTH-1:0]        opb_p1;
    logic [DATA_WIDTH:0]          mul_sum_p1;
    logic [DATA_WIDTH-1:0]        step_hi_p1;
    logic [DATA_WIDTH-1:0]        step_lo_p1;
    logic                         iter_c_p1;
    logic                         iter_v_p1;
`ifdef EX_DIVIDER_EN
    logic [DATA_WIDTH:0]          div_part_p1;
    logic [DATA_WIDTH:0]          div_diff_p1;
    logic                         div_ge_p1;
`endif

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction_in[31:30], instruction_in[25:DATA_WIDTH]};

    // ---- stage p0: decode, operand forwarding, single-cycle ALU ----
    assign op_p0     = instruction_in[29:26];
    assign imm_p0    = instruction_in[DATA_WIDTH-1:0];
    assign top_op_p0 = pick_operand(alu_top_select, top_in, fwd_ex_mem, fwd_mem_wb, imm_p0);
    assign bot_op_p0 = pick_operand(alu_bot_select, bot_in, fwd_ex_mem, fwd_mem_wb, imm_p0);
    assign top_s_p0  = top_op_p0;

`ifdef EX_DIVIDER_EN
    assign is_multi_p0 = (op_p0 == OP_MUL) || (op_p0 == OP_DIV);
`else
    assign is_multi_p0 = (op_p0 == OP_MUL);
`endif

    always_comb begin
        wide_p0    = '0;
        alu_res_p0 = '0;
        alu_c_p0   = 1'b0;
        alu_v_p0   = 1'b0;
        case (op_p0)
            OP_ADD: begin
                wide_p0    = {1'b0, top_op_p0} + {1'b0, bot_op_p0};
                alu_res_p0 = wide_p0[MSB:0];
                alu_c_p0   = wide_p0[DATA_WIDTH];
                alu_v_p0   = (top_op_p0[MSB] == bot_op_p0[MSB]) &&
                             (alu_res_p0[MSB] != top_op_p0[MSB]);
            end
            OP_SUB: begin
                // The extra MSB of a zero-extended difference is the borrow.
                wide_p0    = {1'b0, top_op_p0} - {1'b0, bot_op_p0};
                alu_res_p0 = wide_p0[MSB:0];
                alu_c_p0   = wide_p0[DATA_WIDTH];
                alu_v_p0   = (top_op_p0[MSB] != bot_op_p0[MSB]) &&
                             (alu_res_p0[MSB] != top_op_p0[MSB]);
            end
            OP_AND:  alu_res_p0 = top_op_p0 & bot_op_p0;
            OP_OR:   alu_res_p0 = top_op_p0 | bot_op_p0;
            OP_XOR:  alu_res_p0 = top_op_p0 ^ bot_op_p0;
            OP_NOT:  alu_res_p0 = ~top_op_p0;
            OP_SHL: begin
                alu_res_p0 = {top_op_p0[MSB-1:0], 1'b0};
                alu_c_p0   = top_op_p0[MSB];
            end
            OP_SHR: begin
                alu_res_p0 = {1'b0, top_op_p0[MSB:1]};
                alu_c_p0   = top_op_p0[0];
            end
            OP_ASR: begin
                alu_res_p0 = top_s_p0 >>> 1;
                alu_c_p0   = top_op_p0[0];
            end
            OP_PASA: alu_res_p0 = top_op_p0;
            OP_PASB: alu_res_p0 = bot_op_p0;
`ifndef EX_DIVIDER_EN
            // Without the divider, DIV retires at once flagged as invalid.
            OP_DIV:  alu_v_p0 = 1'b1;
`endif
            default: alu_res_p0 = '0;
        endcase
    end

    // ---- stage p1: one multiply / divide iteration per cycle ----
    // Shift-add multiply: work_lo holds the multiplier and collects the low
    // product bits, work_hi accumulates the high byte.
    assign mul_sum_p1 = {1'b0, work_hi_p1} + (work_lo_p1[0] ? {1'b0, opb_p1} : '0);

`ifdef EX_DIVIDER_EN
    // Restoring divide: work_hi is the partial remainder, work_lo shifts the
    // dividend out and the quotient in. A zero divisor always "fits", so the
    // quotient saturates to all ones and the remainder ends as the dividend.
    assign div_part_p1 = {work_hi_p1, work_lo_p1[MSB]};
    assign div_ge_p1   = (div_part_p1 >= {1'b0, opb_p1});
    assign div_diff_p1 = div_part_p1 - {1'b0, opb_p1};
`endif

    always_comb begin
        step_hi_p1 = mul_sum_p1[DATA_WIDTH:1];
        step_lo_p1 = {mul_sum_p1[0], work_lo_p1[MSB:1]};
        iter_v_p1  = 1'b0;
`ifdef EX_DIVIDER_EN
        if (state == S_DIV) begin
            step_hi_p1 = div_ge_p1 ? div_diff_p1[MSB:0] : div_part_p1[MSB:0];
            step_lo_p1 = {work_lo_p1[MSB-1:0], div_ge_p1};
            iter_v_p1  = (opb_p1 == '0);
        end
`endif
        iter_c_p1 = (state == S_MUL) && (step_hi_p1 != '0);
    end

    always_comb begin
        state_nxt       = state;
        busy            = 1'b0;
        accept_multi_p0 = 1'b0;
        load_single_p0  = 1'b0;
        load_iter_p1    = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_in) begin
                    if (is_multi_p0) begin
                        accept_multi_p0 = 1'b1;
                        busy            = 1'b1;
`ifdef EX_DIVIDER_EN
                        state_nxt = (op_p0 == OP_DIV) ? S_DIV : S_MUL;
`else
                        state_nxt = S_MUL;
`endif
                    end else begin
                        load_single_p0 = 1'b1;
                    end
                end
            end
            default: begin
                // Drop busy one cycle early so ID/EX loads the next
                // instruction while the final iteration completes.
                busy = (cnt_p1 < LAST_ITER);
                if (cnt_p1 == LAST_ITER) begin
                    load_iter_p1 = 1'b1;
                    state_nxt    = S_IDLE;
                end
            end
        endcase
        if (reset) begin
            busy = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt_p1 <= '0;
        end else begin
            state <= state_nxt;
            if (accept_multi_p0) begin
                cnt_p1 <= '0;
            end else if (state != S_IDLE) begin
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
        end
    end

    // Working registers are pure datapath; control alone decides when they matter.
    always_ff @(posedge clock) begin
        if (accept_multi_p0) begin
            work_hi_p1 <= '0;
            work_lo_p1 <= top_op_p0;
            opb_p1     <= bot_op_p0;
        end else if (state != S_IDLE) begin
            work_hi_p1 <= step_hi_p1;
            work_lo_p1 <= step_lo_p1;
        end
    end

    // ---- stage p2: EX/MEM-facing result registers ----
    always_ff @(posedge clock) begin
        if (reset) begin
            result_out    <= '0;
            result_hi_out <= '0;
            flags_out     <= '0;
            valid_out     <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (load_single_p0) begin
                result_out    <= alu_res_p0;
                result_hi_out <= '0;
                flags_out     <= pack_flags(alu_res_p0, alu_c_p0, alu_v_p0);
                valid_out     <= 1'b1;
            end else if (load_iter_p1) begin
                result_out    <= step_lo_p1;
                result_hi_out <= step_hi_p1;
                flags_out     <= pack_flags(step_lo_p1, iter_c_p1, iter_v_p1);
                valid_out     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic [3:0] fl;
    } exp_t;

`ifdef EX_DIVIDER_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [4:0]  alu_top_select;
    logic [4:0]  alu_bot_select;
    logic [7:0]  top_in;
    logic [7:0]  bot_in;
    logic [31:0] instruction_in;
    logic [7:0]  fwd_ex_mem;
    logic [7:0]  fwd_mem_wb;
    logic [7:0]  result_out;
    logic [7:0]  result_hi_out;
    logic [3:0]  flags_out;
    logic        valid_out;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;
    exp_t exp_q[$];

    ex_stage #(.DATA_WIDTH(8), .ITER(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .valid_in       (valid_in),
        .alu_top_select (alu_top_select),
        .alu_bot_select (alu_bot_select),
        .top_in         (top_in),
        .bot_in         (bot_in),
        .instruction_in (instruction_in),
        .fwd_ex_mem     (fwd_ex_mem),
        .fwd_mem_wb     (fwd_mem_wb),
        .result_out     (result_out),
        .result_hi_out  (result_hi_out),
        .flags_out      (flags_out),
        .valid_out      (valid_out),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sel_val(input int sel, input int rf, input int fem, input int fmw, input int imm);
        case (sel)
            0: return rf;
            1: return fem;
            2: return fmw;
            3: return imm;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int r, h, c, v, sa, sb, s;
        r = 0; h = 0; c = 0; v = 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (op)
            0: begin s = a + b; r = s & 255; c = (s > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            1: begin s = a - b; r = s & 255; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (~a) & 255;
            6: begin r = (a * 2) & 255; c = a / 128; end
            7: begin r = a / 2; c = a % 2; end
            8: begin r = (a / 2) + (a & 128); c = a % 2; end
            9: r = a;
            10: r = b;
            11: begin s = a * b; r = s % 256; h = s / 256; c = (h != 0); end
            12: begin
                if (DIV_EN) begin
                    if (b == 0) begin r = 255; h = a; v = 1; end
                    else begin r = a / b; h = a % b; end
                end else begin
                    v = 1;
                end
            end
            default: r = 0;
        endcase
        e.res = 8'(r);
        e.hi  = 8'(h);
        e.fl  = {(r == 0), (r >= 128), (c != 0), (v != 0)};
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [4:0] ts, input logic [4:0] bs,
                         input logic [7:0] t, input logic [7:0] b, input logic [7:0] fem,
                         input logic [7:0] fmw, input logic [7:0] imm);
        @(posedge clock); #1;
        valid_in       = 1'b1;
        alu_top_select = ts;
        alu_bot_select = bs;
        top_in         = t;
        bot_in         = b;
        fwd_ex_mem     = fem;
        fwd_mem_wb     = fmw;
        instruction_in = {2'b10, op, 18'h15A5A, imm};
    endtask

    task automatic bubble();
        @(posedge clock); #1;
        valid_in = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] r, input logic [7:0] h, input logic [3:0] f);
        exp_t e;
        e.res = r; e.hi = h; e.fl = f;
        exp_q.push_back(e);
    endtask

    task automatic push_model(input int op, input int ts, input int bs, input int t, input int b,
                              input int fem, input int fmw, input int imm);
        exp_q.push_back(model(op, sel_val(ts, t, fem, fmw, imm), sel_val(bs, b, fem, fmw, imm)));
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clock);
            if (valid_out === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1'b1);
    endtask

    // Scoreboard: every valid_out pulse retires the oldest expected result.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset === 1'b0 && valid_out !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", valid_out, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("result_out", result_out, e.res);
                check("result_hi_out", result_hi_out, e.hi);
                check("flags_out", flags_out, e.fl);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int         busy_cnt;
        logic       vseen;
        logic       last_busy;
        logic [3:0] rop;
        logic [4:0] rts, rbs;
        logic [7:0] rt, rb, rf1, rf2, rim;

        // Reset with a MUL presented: busy must stay low while reset is high.
        reset          = 1'b1;
        valid_in       = 1'b1;
        alu_top_select = 5'd0;
        alu_bot_select = 5'd0;
        top_in         = 8'h12;
        bot_in         = 8'h34;
        fwd_ex_mem     = 8'h00;
        fwd_mem_wb     = 8'h00;
        instruction_in = {2'b00, 4'd11, 18'h0, 8'h00};
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_result", result_out, 8'h00);
        check("reset_hi", result_hi_out, 8'h00);
        check("reset_flags", flags_out, 4'h0);
        check("reset_valid", valid_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        @(posedge clock); #1;
        reset    = 1'b0;
        valid_in = 1'b0;

        // ADD overflow into the sign bit, single-cycle latency and one-cycle pulse.
        drive(4'd0, 5'd0, 5'd0, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h00);
        push_exp(8'h80, 8'h00, 4'b0101);
        @(negedge clock);
        check("add_busy_low", busy, 1'b0);
        check("add_no_valid_T", valid_out, 1'b0);
        bubble();
        @(negedge clock);
        check("add_valid_T1", valid_out, 1'b1);
        @(negedge clock);
        check("add_valid_one_cycle", valid_out, 1'b0);

        // Back-to-back SUBs: borrow and zero results, one per cycle.
        drive(4'd1, 5'd0, 5'd0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
        push_exp(8'hFF, 8'h00, 4'b0110);
        drive(4'd1, 5'd0, 5'd0, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00);
        push_exp(8'h00, 8'h00, 4'b1000);
        @(negedge clock);
        check("sub1_valid", valid_out, 1'b1);
        bubble();
        @(negedge clock);
        check("sub2_valid", valid_out, 1'b1);

        // Forwarding paths and the out-of-range select.
        drive(4'd0, 5'd1, 5'd3, 8'hAA, 8'h55, 8'h10, 8'h99, 8'h05);
        push_exp(8'h15, 8'h00, 4'b0000);
        drive(4'd9, 5'd2, 5'd0, 8'hAA, 8'h55, 8'h10, 8'h20, 8'h05);
        push_exp(8'h20, 8'h00, 4'b0000);
        drive(4'd9, 5'd7, 5'd0, 8'h33, 8'h55, 8'h10, 8'h20, 8'h05);
        push_exp(8'h00, 8'h00, 4'b1000);
        drive(4'd10, 5'd0, 5'd0, 8'h33, 8'h81, 8'h10, 8'h20, 8'h05);
        push_exp(8'h81, 8'h00, 4'b0100);
        bubble();
        repeat (2) @(negedge clock);

        // MUL 0xFF x 0xFF: busy for exactly T..T+7, valid at T+9.
        drive(4'd11, 5'd0, 5'd0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        push_exp(8'h01, 8'hFE, 4'b0010);
        busy_cnt  = 0;
        vseen     = 1'b0;
        last_busy = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
            if (valid_out === 1'b1) vseen = 1'b1;
            last_busy = busy;
            if (k == 1) begin
                // Operands change after acceptance; the product must not.
                valid_in   = 1'b0;
                top_in     = 8'h00;
                bot_in     = 8'h00;
                fwd_ex_mem = 8'h77;
            end
        end
        check("mul_busy_cycles", busy_cnt, 8);
        check("mul_busy_low_T8", last_busy, 1'b0);
        check("mul_no_early_valid", vseen, 1'b0);
        drive(4'd0, 5'd0, 5'd0, 8'h22, 8'h11, 8'h00, 8'h00, 8'h00);
        push_exp(8'h33, 8'h00, 4'b0000);
        @(negedge clock);
        check("mul_valid_T9", valid_out, 1'b1);
        check("busy_low_T9", busy, 1'b0);
        bubble();
        @(negedge clock);
        check("add_after_mul_valid_T10", valid_out, 1'b1);

        // Reset in cycle T+4 of a MUL aborts it with no valid_out.
        drive(4'd11, 5'd0, 5'd0, 8'h13, 8'h07, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k == 1) valid_in = 1'b0;
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("busy_in_reset", busy, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_result", result_out, 8'h00);
        check("abort_hi", result_hi_out, 8'h00);
        check("abort_flags", flags_out, 4'h0);
        check("abort_valid", valid_out, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (10) @(negedge clock);
        drive(4'd0, 5'd0, 5'd0, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00);
        push_exp(8'h07, 8'h00, 4'b0000);
        bubble();
        @(negedge clock);
        check("fresh_add_valid", valid_out, 1'b1);

        // Divide.
        if (DIV_EN) begin
            drive(4'd12, 5'd0, 5'd0, 8'd100, 8'd7, 8'h00, 8'h00, 8'h00);
            push_exp(8'h0E, 8'h02, 4'b0000);
            @(negedge clock);
            check("div_busy_T", busy, 1'b1);
            bubble();
            wait_valid(12, "div_done");
            drive(4'd12, 5'd0, 5'd0, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00);
            push_exp(8'hFF, 8'h2A, 4'b0101);
            bubble();
            wait_valid(12, "div0_done");
        end else begin
            drive(4'd12, 5'd0, 5'd0, 8'd100, 8'd7, 8'h00, 8'h00, 8'h00);
            push_exp(8'h00, 8'h00, 4'b1001);
            @(negedge clock);
            check("nodiv_busy", busy, 1'b0);
            bubble();
            @(negedge clock);
            check("nodiv_valid_T1", valid_out, 1'b1);
        end

        // Random mix against the reference model.
        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(0, 15));
            rts = 5'($urandom_range(0, 7));
            rbs = 5'($urandom_range(0, 7));
            rt  = 8'($urandom());
            rb  = 8'($urandom());
            rf1 = 8'($urandom());
            rf2 = 8'($urandom());
            rim = 8'($urandom());
            drive(rop, rts, rbs, rt, rb, rf1, rf2, rim);
            push_model(int'(rop), int'(rts), int'(rbs), int'(rt), int'(rb), int'(rf1), int'(rf2), int'(rim));
            if (rop == 4'd11 || (rop == 4'd12 && DIV_EN)) begin
                bubble();
                wait_valid(12, "rand_multi_done");
            end
        end
        bubble();
        repeat (3) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
